dmem_port_arbiter: RTL

- Shares the single-ported data memory between two requesters: the core MEM stage (port c) and a debug/loader port (port d).
- Drives the memory strobes, address and write data, and returns read data to the owning requester after a fixed latency.
- Raises a stall to the core pipeline when the core loses arbitration.
- Core has default priority. An aging counter guarantees the debug port is not starved.

---
 rtl/dmem_port_arbiter.sv | 97 +++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter for a single-ported data memory: core port c has default
// priority, debug port d is protected from starvation by an aging counter.
module dmem_port_arbiter #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 9,
   parameter int RD_LAT   = 1,
   parameter int MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_gnt,
   output logic              c_stall,
   output logic              c_rvalid,
   output logic [DATA_W-1:0] c_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_wr,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic [15:0]       conflict_cnt
);

   logic [2:0]        wait_cnt;
   logic [RD_LAT-1:0] pipe_vld;
   logic [RD_LAT-1:0] pipe_own;   // 1 = read belongs to port d
   logic              d_wins;
   logic              ret_vld;

   // NOTE: every signal assigned here gets a default first so no latch is inferred.
   always_comb begin
      d_wins      = d_req & (~c_req | (int'(wait_cnt) >= MAX_WAIT));
      c_gnt       = ~reset & c_req & ~d_wins;
      d_gnt       = ~reset & d_wins;
      c_stall     = c_req & ~c_gnt;
      mem_wr      = 1'b0;
      mem_rd      = 1'b0;
      mem_addr    = '0;
      mem_wr_data = '0;
      if (c_gnt) begin
         mem_wr      = c_we;
         mem_rd      = ~c_we;
         mem_addr    = c_addr;
         mem_wr_data = c_wdata;
      end else if (d_gnt) begin
         mem_wr      = d_we;
         mem_rd      = ~d_we;
         mem_addr    = d_addr;
         mem_wr_data = d_wdata;
      end
   end

   // Returns landing while reset is held belong to reads issued before reset.
   always_comb begin
      ret_vld  = pipe_vld[RD_LAT-1] & ~reset;
      c_rvalid = ret_vld & ~pipe_own[RD_LAT-1];
      d_rvalid = ret_vld & pipe_own[RD_LAT-1];
      c_rdata  = c_rvalid ? mem_rd_data : '0;
      d_rdata  = d_rvalid ? mem_rd_data : '0;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt     <= '0;
         conflict_cnt <= '0;
         pipe_vld     <= '0;
         pipe_own     <= '0;
      end else begin
         if (d_gnt || !d_req)
            wait_cnt <= '0;
         else if (wait_cnt != 3'd7)
            wait_cnt <= wait_cnt + 3'd1;

         if (c_req && d_req && conflict_cnt != 16'hFFFF)
            conflict_cnt <= conflict_cnt + 16'd1;

         pipe_vld[0] <= mem_rd;
         pipe_own[0] <= d_gnt;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_own[i] <= pipe_own[i-1];
         end
      end
   end

endmodule
